// File: rtl/fltres_frame_packer_pkg.sv
// Shared types and helpers for the filtered-result frame packer.
package fltres_frame_packer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        SEQ_H,
        SEQ_L,
        CNT,
        DATA,
        CSUM
    } state_t;

    localparam logic [15:0] HDR_WORD_DEFAULT = 16'hA55A;
    localparam int unsigned FRAME_OVERHEAD   = 6;

    // Two's complement of the running sum so the whole frame sums to zero.
    function automatic logic [7:0] frame_csum(input logic [7:0] sum);
        return 8'(~sum + 8'd1);
    endfunction

    // Big-endian byte select: idx 0 is the most significant byte.
    function automatic logic [7:0] sample_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/fltres_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a one-entry lookahead read port.
module fltres_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata_c,
    output logic [WIDTH-1:0]         peek_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign full_c  = (level == LW'(DEPTH));
    assign empty_c = (level == '0);
    assign do_push = push & ~full_c;
    assign do_pop  = pop & ~empty_c;
    assign rdata_c = mem[rd_ptr];
    assign peek_c  = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fltres_frame_packer.sv
// Buffers strobed 32-bit filter results and emits checksummed byte frames on a valid/ready stream.
module fltres_frame_packer
    import fltres_frame_packer_pkg::*;
#(
    parameter int unsigned SAMPLES_PER_FRAME = 64,
    parameter int unsigned FIFO_DEPTH        = 256,
    parameter logic [15:0] HDR_WORD          = HDR_WORD_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   fltres_in,
    input  logic                          fltres_strobe,
    input  logic                          enable,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_last,
    output logic [15:0]                   seq_num,
    output logic [15:0]                   overflow_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]  N_BYTE      = 8'(SAMPLES_PER_FRAME);
    localparam logic [7:0]  LAST_SAMPLE = 8'(SAMPLES_PER_FRAME - 1);

    state_t      state;
    logic        strobe_d;
    logic        push_c;
    logic        pop_c;
    logic        hs_c;
    logic        fifo_full_c;
    logic        fifo_empty_c;
    logic [31:0] head_c;
    logic [31:0] head_next_c;
    logic [1:0]  byte_idx;
    logic [7:0]  sample_cnt;
    logic [7:0]  sum;

    assign push_c = fltres_strobe & ~strobe_d;
    assign hs_c   = tx_valid & tx_ready;
    assign pop_c  = hs_c && (state == DATA) && (byte_idx == 2'd3) && !fifo_empty_c;

    fltres_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_c),
        .wdata   (fltres_in),
        .pop     (pop_c),
        .rdata_c (head_c),
        .peek_c  (head_next_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c),
        .level   (fifo_level)
    );

    // Strobe edge detect and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_d     <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            strobe_d <= fltres_strobe;
            if (push_c && fifo_full_c && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    // Frame sequencer: the registered byte always holds the one currently offered,
    // and each handshake loads its successor so the stream has no bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            tx_data    <= '0;
            seq_num    <= '0;
            byte_idx   <= '0;
            sample_cnt <= '0;
            sum        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sum        <= '0;
                    byte_idx   <= '0;
                    sample_cnt <= '0;
                    if (enable && (fifo_level >= LVL_W'(SAMPLES_PER_FRAME))) begin
                        state    <= HDR0;
                        tx_valid <= 1'b1;
                        tx_data  <= HDR_WORD[15:8];
                    end
                end
                default: begin
                    if (hs_c) begin
                        sum <= sum + tx_data;
                        case (state)
                            HDR0: begin
                                state   <= HDR1;
                                tx_data <= HDR_WORD[7:0];
                            end
                            HDR1: begin
                                state   <= SEQ_H;
                                tx_data <= seq_num[15:8];
                            end
                            SEQ_H: begin
                                state   <= SEQ_L;
                                tx_data <= seq_num[7:0];
                            end
                            SEQ_L: begin
                                state   <= CNT;
                                tx_data <= N_BYTE;
                            end
                            CNT: begin
                                state   <= DATA;
                                tx_data <= sample_byte(head_c, 2'd0);
                            end
                            DATA: begin
                                if (byte_idx != 2'd3) begin
                                    byte_idx <= byte_idx + 2'd1;
                                    tx_data  <= sample_byte(head_c, byte_idx + 2'd1);
                                end else if (sample_cnt == LAST_SAMPLE) begin
                                    state   <= CSUM;
                                    tx_last <= 1'b1;
                                    tx_data <= frame_csum(sum + tx_data);
                                end else begin
                                    // Head is popped this cycle; its successor is already visible on the peek port.
                                    byte_idx   <= 2'd0;
                                    sample_cnt <= sample_cnt + 8'd1;
                                    tx_data    <= sample_byte(head_next_c, 2'd0);
                                end
                            end
                            CSUM: begin
                                state    <= IDLE;
                                tx_valid <= 1'b0;
                                tx_last  <= 1'b0;
                                tx_data  <= '0;
                                seq_num  <= seq_num + 16'd1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fltres_frame_packer.md
Name: fltres_frame_packer

Overview:
- Sits directly downstream of the FIR top, on the same clk.
- Captures each 32-bit filtered result (A1_fltres) on the rising edge of its sample strobe (clk_fltres) and buffers it in a FIFO.
- Emits fixed-size byte frames over a valid/ready byte stream toward the TEMAC/UDP transmit path.
- Each frame carries a header, a sequence number, the sample count, big-endian samples and a checksum.

Parameters:
- SAMPLES_PER_FRAME, 64, samples per frame; legal range 1..255.
- FIFO_DEPTH, 256, sample FIFO depth in 32-bit words; power of 2, must be >= SAMPLES_PER_FRAME.
- HDR_WORD, 16'hA55A, two header bytes, sent high byte first.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fltres_in  in  32  filtered sample; stable while fltres_strobe is high.
- fltres_strobe  in  1  sample strobe (clk_fltres); generated in the clk domain; rising edge = new sample.
- enable  in  1  permits the start of new frames.
- tx_data  out  8  stream byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- tx_last  out  1  marks the final (checksum) byte of a frame.
- seq_num  out  16  sequence number of the next/current frame.
- overflow_cnt  out  16  count of dropped samples; saturates at 16'hFFFF.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - tx_valid=0, tx_last=0, tx_data=0, seq_num=0, overflow_cnt=0, fifo_level=0.
  - FSM goes to IDLE; strobe edge register cleared to 0.
  - Reset mid-frame drops the partial frame with no tail bytes and empties the FIFO.
- Capture:
  - Edge detect: strobe_d <= fltres_strobe; push = fltres_strobe & ~strobe_d.
  - fltres_in is written in the push cycle. No synchronizer is used; the strobe is same-domain.
- Full FIFO:
  - A push while full is dropped and overflow_cnt increments (saturating).
  - Fullness is evaluated before any same-cycle pop, so a push is dropped even if a pop occurs that cycle.
- FSM states: IDLE, HDR0, HDR1, SEQ_H, SEQ_L, CNT, DATA, CSUM.
  - IDLE -> HDR0 when enable && fifo_level >= SAMPLES_PER_FRAME. The check is made only in IDLE.
  - Each non-IDLE state advances only on a handshake (tx_valid && tx_ready).
  - DATA uses byte_idx 0..3 and sample counter 0..N-1. Bytes are sent MSB first.
  - On the handshake of byte_idx 3, the FIFO is popped. After the last sample the FSM goes to CSUM.
  - CSUM drives tx_last=1. On its handshake: seq_num increments (wrapping FFFF->0000) and the FSM returns to IDLE.
- Byte order: HDR_WORD[15:8], HDR_WORD[7:0], seq[15:8], seq[7:0], N, then 4N sample bytes, then csum.
  - Frame length is 6+4N bytes.
- Checksum:
  - 8-bit running sum of every byte before csum.
  - csum = (-sum) mod 256, so all bytes including csum sum to 0 mod 256.
  - The accumulator clears in IDLE.
- Stream rules:
  - tx_valid is held high through the whole frame with no bubbles. A registered FIFO read (prefetch) is permitted, but no idle cycles may appear in the stream.
  - tx_data and tx_last must stay stable while tx_valid && !tx_ready.
  - tx_valid does not depend combinationally on tx_ready.
- Enable: deasserting enable mid-frame completes the current frame; no new frame starts.
- Simultaneous push and pop while not full: both occur and fifo_level is unchanged.
- Continuous frames: when back-to-back frames are possible, at least one IDLE cycle separates them.

Decomposition:
- Shared package:
  - FSM state enum.
  - Header constant.
  - Frame overhead constant (6).
  - Checksum function.
- One sub-module: fltres_sync_fifo.
  - Parameterised width/depth, single clock.
  - Provides full, empty and level.
  - First-word-fall-through read.

Test Plan:
- Basic frame, N=2, tx_ready=1, samples 0x00000001 then 0x12345678.
  - Expect bytes A5 5A 00 00 02 00 00 00 01 12 34 56 78 EA.
  - tx_last only on EA; seq_num -> 1 afterwards.
- Backpressure: same stimulus with tx_ready toggling pseudo-randomly.
  - Identical byte sequence.
  - tx_data stable during every stall.
  - No duplicated or skipped bytes.
- Overflow, FIFO_DEPTH=4, N=4, enable=0: push 7 strobes.
  - fifo_level=4, overflow_cnt=3.
  - After enable=1, the frame contains the first 4 samples only.
- Sequence wrap: force seq_num to FFFF via 65535 frames (or a bench-accelerated N=1).
  - Frame shows seq bytes FF FF; the next frame shows 00 00.
- Reset mid-frame: assert rst_n=0 during a DATA byte.
  - tx_valid drops immediately and fifo_level=0.
  - After release, the first byte of the next frame is A5 with seq 00 00.
- Enable drop mid-frame: enable=0 during CNT.
  - The frame completes through csum.
  - FSM stays IDLE with samples pending; no new frame until enable=1.
